rc_arbiter: RTL and testbench

Shares a single `route_compute` instance among the router's input ports. Each port presents the destination router ID of a head flit and receives the computed output direction. Requests are arbitrated round-robin, and the shared unit runs through one register stage. The block sits between the input-port VC buffers and the VC/switch allocators.

---
 rtl/router_pkg.sv | 24 ++
 rtl/route_compute.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rc_arbiter.sv | 142 ++++++++++++++
 tb/tb_rc_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router types: output direction encoding, route-compute port FSM states
// and default mesh dimensions.
package router_pkg;

  // North/South follow the row index, which grows towards South.
  typedef enum logic [1:0] {
    DIR_NORTH = 2'd0,
    DIR_EAST  = 2'd1,
    DIR_SOUTH = 2'd2,
    DIR_WEST  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } rc_state_t;

  localparam int DEF_NUM_PORTS      = 5;
  localparam int DEF_NUM_ROUTERS    = 16;
  localparam int DEF_ROUTER_PER_ROW = 4;

endpackage

// File: rtl/route_compute.sv
// Dimension-ordered (X then Y) route computation for a 2-D mesh.
// A destination equal to the current router yields DIR_NORTH (raw encoding 0).
module route_compute
  import router_pkg::*;
#(
  parameter  int NUM_ROUTERS    = DEF_NUM_ROUTERS,
  parameter  int ROUTER_PER_ROW = DEF_ROUTER_PER_ROW,
  localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS)
) (
  input  logic [ROUTER_ID_BITS-1:0] i_current,
  input  logic [ROUTER_ID_BITS-1:0] i_dest,
  output dir_t                      o_dir
);

  int w_cur_x, w_cur_y, w_dst_x, w_dst_y;

  always_comb begin
    w_cur_x = int'(i_current) % ROUTER_PER_ROW;
    w_cur_y = int'(i_current) / ROUTER_PER_ROW;
    w_dst_x = int'(i_dest) % ROUTER_PER_ROW;
    w_dst_y = int'(i_dest) / ROUTER_PER_ROW;
    if (w_dst_x > w_cur_x)      o_dir = DIR_EAST;
    else if (w_dst_x < w_cur_x) o_dir = DIR_WEST;
    else if (w_dst_y > w_cur_y) o_dir = DIR_SOUTH;
    else                        o_dir = DIR_NORTH;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps,
// giving one-hot and index forms of the single grant.
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_sum         = '0;
    w_idx         = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_idx = w_sum[IW-1:0];
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid  = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/rc_arbiter.sv
// Shares one route_compute among NUM_PORTS requesters via round-robin and one stage register.
// Optional macro RC_LOCAL_EJECT_EN: report local destinations on rsp_local and force rsp_dir to 0.
module rc_arbiter
  import router_pkg::*;
#(
  parameter  int NUM_PORTS      = DEF_NUM_PORTS,
  parameter  int NUM_ROUTERS    = DEF_NUM_ROUTERS,
  parameter  int ROUTER_PER_ROW = DEF_ROUTER_PER_ROW,
  localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  localparam int PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [ROUTER_ID_BITS-1:0]                 current_router,
  input  logic [NUM_PORTS-1:0]                      req_valid,
  input  logic [NUM_PORTS-1:0][ROUTER_ID_BITS-1:0]  req_dest,
  output logic [NUM_PORTS-1:0]                      req_ready,
  output logic [NUM_PORTS-1:0]                      rsp_valid,
  output logic [NUM_PORTS-1:0][1:0]                 rsp_dir,
  output logic [NUM_PORTS-1:0]                      rsp_local,
  input  logic [NUM_PORTS-1:0]                      rsp_ack,
  output logic [NUM_PORTS-1:0][1:0]                 o_dbg_state,
  output logic [PW-1:0]                             o_dbg_rr_ptr
);

  // Handshake: a request transfers on an edge where req_valid & req_ready;
  // a result is offered while rsp_valid and retired on an edge where rsp_ack is high.
  rc_state_t r_state     [NUM_PORTS];
  rc_state_t w_state_nxt [NUM_PORTS];

  logic [NUM_PORTS-1:0][ROUTER_ID_BITS-1:0] r_dest;
  logic [NUM_PORTS-1:0][1:0]                r_dir;
  logic [PW-1:0]                            r_rr_ptr;
  logic                                     r_stg_valid;
  logic [PW-1:0]                            r_stg_port;
  logic [ROUTER_ID_BITS-1:0]                r_stg_dest;

  logic [NUM_PORTS-1:0] w_pend, w_grant, w_wb;
  logic [PW-1:0]        w_grant_idx;
  logic                 w_grant_valid;
  dir_t                 w_rc_dir;

`ifdef RC_LOCAL_EJECT_EN
  logic [NUM_PORTS-1:0] r_local;
  logic                 w_is_local;
  assign w_is_local = (r_stg_dest == current_router);
`endif

  rr_arbiter #(.N(NUM_PORTS)) u_rr_arbiter (
    .i_req         (w_pend),
    .i_ptr         (r_rr_ptr),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  route_compute #(
    .NUM_ROUTERS    (NUM_ROUTERS),
    .ROUTER_PER_ROW (ROUTER_PER_ROW)
  ) u_route_compute (
    .i_current (current_router),
    .i_dest    (r_stg_dest),
    .o_dir     (w_rc_dir)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= w_state_nxt[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_state_nxt[p] = r_state[p];
      unique case (r_state[p])
        IDLE:    if (req_valid[p]) w_state_nxt[p] = PEND;
        PEND:    if (w_grant[p])   w_state_nxt[p] = BUSY;
        BUSY:    if (w_wb[p])      w_state_nxt[p] = DONE;
        DONE:    if (rsp_ack[p])   w_state_nxt[p] = IDLE;
        default: w_state_nxt[p] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]   = (r_state[p] == IDLE);
      rsp_valid[p]   = (r_state[p] == DONE);
      w_pend[p]      = (r_state[p] == PEND);
      w_wb[p]        = r_stg_valid && (r_stg_port == PW'(p));
      o_dbg_state[p] = r_state[p];
    end
    rsp_dir      = r_dir;
`ifdef RC_LOCAL_EJECT_EN
    rsp_local    = r_local;
`else
    rsp_local    = '0;
`endif
    o_dbg_rr_ptr = r_rr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_stg_valid <= 1'b0;
      r_stg_port  <= '0;
      r_stg_dest  <= '0;
      r_dest      <= '0;
      r_dir       <= '0;
`ifdef RC_LOCAL_EJECT_EN
      r_local     <= '0;
`endif
    end else begin
      r_stg_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_rr_ptr   <= (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
        r_stg_port <= w_grant_idx;
        r_stg_dest <= r_dest[w_grant_idx];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_state[p] == IDLE && req_valid[p]) r_dest[p] <= req_dest[p];
        // Result registers only change on write-back, so they hold through DONE.
        if (w_wb[p]) begin
`ifdef RC_LOCAL_EJECT_EN
          r_local[p] <= w_is_local;
          r_dir[p]   <= w_is_local ? 2'b00 : w_rc_dir;
`else
          r_dir[p]   <= w_rc_dir;
`endif
        end
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_dest_chk
    a_dest_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gp] && req_ready[gp]) |-> (int'(req_dest[gp]) < NUM_ROUTERS));
  end

endmodule

// File: tb/tb_rc_arbiter.sv
// Self-checking bench for rc_arbiter: per-port expected-result queues filled when
// requests are driven, popped when each new response appears.
module tb_rc_arbiter;

  localparam int NP = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      current_router = 4'd5;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0][3:0] req_dest = '0;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   rsp_valid;
  logic [NP-1:0][1:0] rsp_dir;
  logic [NP-1:0]   rsp_local;
  logic [NP-1:0]   rsp_ack = '0;
  logic [NP-1:0][1:0] dbg_state;
  logic [2:0]      dbg_rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_edge = 0;

  logic [2:0]    exp_q [NP][$];  // {local, dir}
  logic [NP-1:0] rsp_seen = '0;
  logic [NP-1:0] rsp_got  = '0;
  int            rsp_cyc [NP];

  rc_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .current_router (current_router),
    .req_valid      (req_valid),
    .req_dest       (req_dest),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_dir        (rsp_dir),
    .rsp_local      (rsp_local),
    .rsp_ack        (rsp_ack),
    .o_dbg_state    (dbg_state),
    .o_dbg_rr_ptr   (dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // Independent XY-routing reference: E=1, W=3, S=2 (row grows), N=0.
  function automatic logic [2:0] model_rsp(input int cur, input int dst);
    int cx = cur % 4;
    int cy = cur / 4;
    int dx = dst % 4;
    int dy = dst / 4;
    logic [1:0] d;
    if (dx > cx)      d = 2'd1;
    else if (dx < cx) d = 2'd3;
    else if (dy > cy) d = 2'd2;
    else              d = 2'd0;
`ifdef RC_LOCAL_EJECT_EN
    if (cur == dst) return 3'b100;
`endif
    return {1'b0, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ack   = '0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    rsp_got = '0;
  endtask

  task automatic send(input logic [NP-1:0] mask, input logic [NP-1:0][3:0] dests);
    check("ready_before_send", 32'(req_ready & mask), 32'(mask));
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        req_dest[p] = dests[p];
        exp_q[p].push_back(model_rsp(int'(current_router), int'(dests[p])));
      end
    end
    req_valid = mask;
    tick();
    acc_edge  = cyc;
    req_valid = '0;
  endtask

  task automatic ack(input logic [NP-1:0] mask);
    rsp_ack = mask;
    tick();
    rsp_ack = '0;
  endtask

  task automatic wait_got(input logic [NP-1:0] mask, input int budget);
    int n = 0;
    while (((rsp_got & mask) != mask) && (n < budget)) begin
      tick();
      n++;
    end
    check("rsp_arrived", 32'(rsp_got & mask), 32'(mask));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    for (int p = 0; p < NP; p++) begin
      if (rsp_valid[p] && !rsp_seen[p]) begin
        rsp_seen[p] = 1'b1;
        rsp_got[p]  = 1'b1;
        rsp_cyc[p]  = cyc;
        if (exp_q[p].size() == 0) begin
          check($sformatf("unexpected_rsp_p%0d", p), 32'd1, 32'd0);
        end else begin
          e = exp_q[p].pop_front();
          check($sformatf("rsp_dir_p%0d", p), 32'(rsp_dir[p]), 32'(e[1:0]));
          check($sformatf("rsp_local_p%0d", p), 32'(rsp_local[p]), 32'(e[2]));
        end
      end else if (!rsp_valid[p]) begin
        rsp_seen[p] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NP-1:0][3:0] d;
    logic [NP-1:0]      v;
    logic [NP-1:0]      a;

    // Reset then idle
    #1;
    current_router = 4'd5;
    do_reset(2);
    check("reset_ready", 32'(req_ready), 32'h1f);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_dir", 32'(rsp_dir), 32'h0);
    check("reset_rsp_local", 32'(rsp_local), 32'h0);
    check("reset_rr_ptr", 32'(dbg_rr_ptr), 32'h0);
    ack(5'h1f);
    check("idle_ack_state", 32'(dbg_state), 32'h0);
    check("idle_ack_ready", 32'(req_ready), 32'h1f);
    check("idle_ack_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single request: router 5 -> 8 routes West; DONE registered two edges after acceptance
    d = '0;
    d[0] = 4'd8;
    send(5'b00001, d);
    wait_got(5'b00001, 10);
    check("single_latency", 32'(rsp_cyc[0] - acc_edge), 32'd2);
    check("single_dir_west", 32'(rsp_dir[0]), 32'd3);
    check("single_rr_ptr", 32'(dbg_rr_ptr), 32'd1);
    ack(5'b00001);
    check("single_ready_after_ack", 32'(req_ready), 32'h1f);

    // All five ports at once from rr_ptr = 0
    do_reset(1);
    for (int p = 0; p < NP; p++) d[p] = 4'($urandom_range(0, 15));
    send(5'h1f, d);
    wait_got(5'h1f, 20);
    for (int p = 0; p < NP; p++)
      check($sformatf("rr_order_p%0d", p), 32'(rsp_cyc[p] - acc_edge), 32'(2 + p));
    check("all_rr_ptr_end", 32'(dbg_rr_ptr), 32'd0);
    check("all_rsp_valid", 32'(rsp_valid), 32'h1f);
    ack(5'h1f);
    check("all_ready_after_ack", 32'(req_ready), 32'h1f);

    // Hold port 2 for 10 cycles, then ack
    rsp_got = '0;
    d = '0;
    d[2] = 4'd3;
    send(5'b00100, d);
    wait_got(5'b00100, 10);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(rsp_valid[2]), 32'd1);
      check("hold_dir", 32'(rsp_dir[2]), 32'(model_rsp(5, 3) & 3'b011));
      check("hold_ready_low", 32'(req_ready[2]), 32'd0);
      tick();
    end
    rsp_ack[2] = 1'b1;
    check("ack_cycle_ready_low", 32'(req_ready[2]), 32'd0);
    tick();
    rsp_ack[2] = 1'b0;
    check("ack_next_ready_high", 32'(req_ready[2]), 32'd1);
    check("ack_next_rsp_valid", 32'(rsp_valid[2]), 32'd0);

    // Reset mid-operation: three PEND plus one BUSY
    do_reset(1);
    for (int p = 0; p < NP; p++) d[p] = 4'($urandom_range(0, 15));
    send(5'b01111, d);
    check("midrst_pend", 32'(dbg_state), 32'b00_01_01_01_01);
    tick();
    check("midrst_busy", 32'(dbg_state), 32'b00_01_01_01_10);
    do_reset(1);
    check("midrst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Local destination
    d = '0;
    d[3] = 4'd5;
    send(5'b01000, d);
    wait_got(5'b01000, 10);
`ifdef RC_LOCAL_EJECT_EN
    check("local_flag", 32'(rsp_local[3]), 32'd1);
    check("local_dir_zero", 32'(rsp_dir[3]), 32'd0);
`else
    check("local_flag_off", 32'(rsp_local[3]), 32'd0);
`endif
    ack(5'b01000);

    // Random traffic from another router with random consumer back-pressure
    current_router = 4'd10;
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      v = '0;
      a = '0;
      for (int p = 0; p < NP; p++) begin
        if (req_ready[p] && ($urandom_range(0, 1) == 1)) begin
          v[p] = 1'b1;
          req_dest[p] = 4'($urandom_range(0, 15));
          exp_q[p].push_back(model_rsp(10, int'(req_dest[p])));
        end
        if (rsp_valid[p] && ($urandom_range(0, 2) == 0)) a[p] = 1'b1;
      end
      req_valid = v;
      rsp_ack   = a;
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 30; i++) begin
      rsp_ack = rsp_valid;
      tick();
    end
    rsp_ack = '0;
    for (int p = 0; p < NP; p++)
      check($sformatf("drain_empty_p%0d", p), 32'(exp_q[p].size()), 32'd0);
    check("drain_idle", 32'(dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
